block_accumulator: RTL and testbench
====================================

BLOCK_ACCUMULATOR -- requirements
Module: block_accumulator

Interface
REQ-001 Parameter BLOCK_LEN, default 64: words per block read; SHALL be a power of two, 2..64.
REQ-002 Parameter TIMEOUT, default 256: idle cycles allowed between words in COLLECT before abort.
REQ-003 Port CLK  input  1: single clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1: reset; one clock, reset is synchronous and active-high.
REQ-005 Port EN_start  input  1: request one block reduction; accepted only when RDY_start=1.
REQ-006 Port RDY_start  output  1: high in IDLE only.
REQ-007 Port EN_blockRead  output  1: one-cycle request to the upstream multiplier to stream its memory.
REQ-008 Port VALID_memVal  input  1: qualifies memVal_data; one word per high cycle.
REQ-009 Port memVal_data  input  32: unsigned product word from the multiplier.
REQ-010 Port VALID_result  output  1: one-cycle pulse; result_sum and result_max are final.
REQ-011 Port result_sum  output  38: unsigned sum of the block's words.
REQ-012 Port result_max  output  32: largest word of the block.
REQ-013 Port ERR_timeout  output  1: one-cycle pulse on timeout abort.

Function
REQ-014 The FSM SHALL have states IDLE, REQ, COLLECT and DONE.
REQ-015 IDLE -> REQ on EN_start=1; EN_start in any other state SHALL be ignored.
REQ-016 REQ SHALL drive EN_blockRead=1 for exactly one cycle, clear the accumulator, word counter and idle counter, then go to COLLECT.
REQ-017 COLLECT: each cycle with VALID_memVal=1 SHALL add zero-extended memVal_data to the 38-bit accumulator, update the running max, increment the word counter and clear the idle counter.
REQ-018 COLLECT: when the word accepted is number BLOCK_LEN (counter = BLOCK_LEN-1 and VALID_memVal=1), the next state SHALL be DONE.
REQ-019 Gaps (VALID_memVal=0) within COLLECT SHALL be tolerated; each gap cycle increments the idle counter.
REQ-020 Idle counter reaching TIMEOUT-1 with VALID_memVal=0 SHALL go to IDLE, pulse ERR_timeout the next cycle, and leave result_sum/result_max unchanged from the previous completed block.
REQ-021 DONE: result_sum and result_max SHALL be loaded from the accumulators and VALID_result pulsed for one cycle, registered; then go to IDLE.
REQ-022 VALID_result SHALL rise exactly 2 cycles after the cycle sampling the final word.
REQ-023 result_sum and result_max SHALL hold their values until the next DONE or reset.
REQ-024 VALID_memVal outside COLLECT SHALL be ignored; no state or output changes.
REQ-025 Sum width: 38 bits SHALL hold 64 x (2^32-1) without overflow; no wrap occurs.
REQ-026 Max compare SHALL be unsigned; ties leave the max unchanged.

Reset
REQ-027 rst=1 on any edge SHALL force IDLE, clear all counters and accumulators, and set outputs to RDY_start=0 for that cycle, EN_blockRead=0, VALID_result=0, ERR_timeout=0, result_sum=0, result_max=0.
REQ-028 The first cycle after rst deasserts SHALL present RDY_start=1.
REQ-029 Reset mid-COLLECT SHALL discard the partial block; words arriving after reset SHALL be ignored until a new EN_start.

Configuration
REQ-030 Macro BLOCK_ACCUMULATOR_MAX_EN: when defined, max tracking per REQ-017/021/026 SHALL be built in.
REQ-031 When BLOCK_ACCUMULATOR_MAX_EN is undefined, no max comparator or register SHALL exist, result_max SHALL be constant 0, and all other behaviour is unchanged.

Verification
REQ-032 EN_start; stream words 2*i, i=0..63, back-to-back -> one EN_blockRead pulse; VALID_result 2 cycles after the last word; result_sum=4032, result_max=126.
REQ-033 Stream 64 words of 0xFFFFFFFF -> result_sum=0x3F_FFFF_FFC0, result_max=0xFFFFFFFF, no ERR_timeout.
REQ-034 Stream 6*4=24 then 1..63 with a 3-cycle gap after every 8th word -> result_sum=2040, result_max=63; VALID_result only after the 64th word.
REQ-035 10 words then silence -> ERR_timeout pulses once 256 idle cycles later; VALID_result stays 0; prior results retained; RDY_start=1.
REQ-036 rst=1 after 30 words, then EN_start and a full 2*i block -> first VALID_result reports 4032 (no leftover sum); stray VALID_memVal while IDLE has no effect.
REQ-037 Build without BLOCK_ACCUMULATOR_MAX_EN and rerun REQ-032 -> result_sum=4032, result_max=0.

Source files
------------

// File: rtl/block_accumulator.sv
// block_accumulator: reduces one streamed block of 32-bit products to a sum and a max.
// Optional max tracking is built only when BLOCK_ACCUMULATOR_MAX_EN is defined.
module block_accumulator #(
  parameter int BLOCK_LEN = 64,
  parameter int TIMEOUT   = 256
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic        EN_start,
  output logic        RDY_start,
  output logic        EN_blockRead,
  input  logic        VALID_memVal,
  input  logic [31:0] memVal_data,
  output logic        VALID_result,
  output logic [37:0] result_sum,
  output logic [31:0] result_max,
  output logic        ERR_timeout
);

  localparam int CW = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_WORD  = CW'(BLOCK_LEN - 1);
  localparam logic [IW-1:0] IDLE_LIMIT = IW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    COLLECT,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [CW-1:0] word_cnt;
  logic [IW-1:0] idle_cnt;
  logic [37:0]   acc_sum;
  logic [37:0]   sum_q;
  logic          valid_q;
  logic          err_q;

  logic take_word;
  logic last_word;
  logic timed_out;

  assign take_word = (state == COLLECT) && VALID_memVal;
  assign last_word = take_word && (word_cnt == LAST_WORD);
  assign timed_out = (state == COLLECT) && !VALID_memVal
                     && (idle_cnt == IDLE_LIMIT);

  // Handshake outputs are forced low during the reset cycle itself.
  assign RDY_start    = (state == IDLE) && !rst;
  assign EN_blockRead = (state == REQ) && !rst;
  assign VALID_result = valid_q;
  assign ERR_timeout  = err_q;
  assign result_sum   = sum_q;

  always_ff @(posedge CLK) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (EN_start) begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        state_nxt = COLLECT;
      end
      COLLECT: begin
        if (last_word) begin
          state_nxt = DONE;
        end else if (timed_out) begin
          state_nxt = IDLE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      word_cnt <= '0;
      idle_cnt <= '0;
      acc_sum  <= '0;
      sum_q    <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      unique case (state)
        REQ: begin
          word_cnt <= '0;
          idle_cnt <= '0;
          acc_sum  <= '0;
        end
        COLLECT: begin
          if (take_word) begin
            acc_sum  <= acc_sum + {6'd0, memVal_data};
            word_cnt <= word_cnt + 1'b1;
            idle_cnt <= '0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
          if (timed_out) begin
            err_q <= 1'b1;
          end
        end
        DONE: begin
          sum_q   <= acc_sum;
          valid_q <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef BLOCK_ACCUMULATOR_MAX_EN
  logic [31:0] acc_max;
  logic [31:0] max_q;

  assign result_max = max_q;

  // Strict compare: an equal word leaves the running max alone.
  always_ff @(posedge CLK) begin
    if (rst) begin
      acc_max <= '0;
      max_q   <= '0;
    end else begin
      unique case (state)
        REQ: begin
          acc_max <= '0;
        end
        COLLECT: begin
          if (take_word && (memVal_data > acc_max)) begin
            acc_max <= memVal_data;
          end
        end
        DONE: begin
          max_q <= acc_max;
        end
        default: begin
        end
      endcase
    end
  end
`else
  assign result_max = '0;
`endif

endmodule

// File: tb/tb_block_accumulator.sv
// tb_block_accumulator: directed scoreboard bench for block_accumulator.
// Expected max follows the BLOCK_ACCUMULATOR_MAX_EN build setting.
module tb_block_accumulator;

  localparam int BLOCK_LEN = 64;
  localparam int TIMEOUT   = 256;

  logic        CLK;
  logic        rst;
  logic        EN_start;
  logic        RDY_start;
  logic        EN_blockRead;
  logic        VALID_memVal;
  logic [31:0] memVal_data;
  logic        VALID_result;
  logic [37:0] result_sum;
  logic [31:0] result_max;
  logic        ERR_timeout;

  block_accumulator #(
    .BLOCK_LEN(BLOCK_LEN),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .CLK         (CLK),
    .rst         (rst),
    .EN_start    (EN_start),
    .RDY_start   (RDY_start),
    .EN_blockRead(EN_blockRead),
    .VALID_memVal(VALID_memVal),
    .memVal_data (memVal_data),
    .VALID_result(VALID_result),
    .result_sum  (result_sum),
    .result_max  (result_max),
    .ERR_timeout (ERR_timeout)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [37:0] sum;
    logic [31:0] mx;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] words[BLOCK_LEN];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          eb_cnt = 0;
  int          vr_cnt = 0;
  int          err_cnt = 0;
  logic [37:0] last_sum = '0;
  logic [31:0] last_max = '0;

  always @(posedge CLK) begin
    if (EN_blockRead) eb_cnt++;
    if (VALID_result) vr_cnt++;
    if (ERR_timeout) err_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_expected(input int n);
    exp_t e;
    e.sum = '0;
    e.mx  = '0;
    for (int i = 0; i < n; i++) begin
      e.sum = e.sum + {6'd0, words[i]};
`ifdef BLOCK_ACCUMULATOR_MAX_EN
      if (words[i] > e.mx) e.mx = words[i];
`endif
    end
    sb.push_back(e);
  endtask

  task automatic start_block(input string tag);
    chk({tag, "_rdy"}, 64'(RDY_start), 64'd1);
    EN_start = 1'b1;
    tick();
    chk({tag, "_en_blockread"}, 64'(EN_blockRead), 64'd1);
    EN_start = 1'b0;
    tick();
    chk({tag, "_en_blockread_low"}, 64'(EN_blockRead), 64'd0);
  endtask

  task automatic send_words(input int n, input int gap_every,
                            input int gap_len);
    for (int i = 0; i < n; i++) begin
      VALID_memVal = 1'b1;
      memVal_data  = words[i];
      tick();
      if (gap_every > 0 && ((i + 1) % gap_every) == 0 && (i + 1) < n) begin
        VALID_memVal = 1'b0;
        memVal_data  = 32'hA5A5_A5A5;
        repeat (gap_len) tick();
      end
    end
    VALID_memVal = 1'b0;
    memVal_data  = '0;
  endtask

  // Called one falling edge after the final word was driven.
  task automatic wait_result(input string tag);
    exp_t e;
    int   k;
    k = 1;
    while (!VALID_result && k < 12) begin
      tick();
      k++;
    end
    chk({tag, "_latency"}, 64'(k), 64'd2);
    if (sb.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 64'(sb.size()), 64'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_sum"}, 64'(result_sum), 64'(e.sum));
      chk({tag, "_max"}, 64'(result_max), 64'(e.mx));
      last_sum = e.sum;
      last_max = e.mx;
    end
    tick();
    chk({tag, "_pulse_low"}, 64'(VALID_result), 64'd0);
    chk({tag, "_sum_hold"}, 64'(result_sum), 64'(last_sum));
  endtask

  initial begin
    int eb0;
    int vr0;
    int er0;
    int k;

    rst          = 1'b1;
    EN_start     = 1'b0;
    VALID_memVal = 1'b0;
    memVal_data  = '0;
    tick();
    tick();
    chk("reset_rdy", 64'(RDY_start), 64'd0);
    chk("reset_en_blockread", 64'(EN_blockRead), 64'd0);
    chk("reset_valid_result", 64'(VALID_result), 64'd0);
    chk("reset_err", 64'(ERR_timeout), 64'd0);
    chk("reset_sum", 64'(result_sum), 64'd0);
    chk("reset_max", 64'(result_max), 64'd0);
    rst = 1'b0;
    tick();
    chk("post_reset_rdy", 64'(RDY_start), 64'd1);

    // Block of 2*i, back to back.
    for (int i = 0; i < BLOCK_LEN; i++) words[i] = 32'(2 * i);
    eb0 = eb_cnt;
    start_block("ramp");
    push_expected(BLOCK_LEN);
    send_words(BLOCK_LEN, 0, 0);
    wait_result("ramp");
    chk("ramp_sum_const", 64'(result_sum), 64'd4032);
    chk("ramp_eb_pulses", 64'(eb_cnt - eb0), 64'd1);

    // All-ones block: widest possible sum.
    for (int i = 0; i < BLOCK_LEN; i++) words[i] = 32'hFFFF_FFFF;
    er0 = err_cnt;
    start_block("ones");
    push_expected(BLOCK_LEN);
    send_words(BLOCK_LEN, 0, 0);
    wait_result("ones");
    chk("ones_sum_const", 64'(result_sum), 64'h3F_FFFF_FFC0);
    chk("ones_no_err", 64'(err_cnt - er0), 64'd0);

    // 24 then 1..63, with a 3-cycle gap after every 8th word.
    words[0] = 32'd24;
    for (int i = 1; i < BLOCK_LEN; i++) words[i] = 32'(i);
    vr0 = vr_cnt;
    start_block("gaps");
    push_expected(BLOCK_LEN);
    send_words(BLOCK_LEN - 1, 8, 3);
    chk("gaps_no_early_result", 64'(vr_cnt - vr0), 64'd0);
    VALID_memVal = 1'b1;
    memVal_data  = words[BLOCK_LEN-1];
    tick();
    VALID_memVal = 1'b0;
    memVal_data  = '0;
    wait_result("gaps");
    chk("gaps_sum_const", 64'(result_sum), 64'd2040);

    // Ten words then silence: abort after TIMEOUT idle cycles.
    for (int i = 0; i < BLOCK_LEN; i++) words[i] = 32'(1000 + i);
    vr0 = vr_cnt;
    er0 = err_cnt;
    start_block("tmo");
    send_words(10, 0, 0);
    k = 1;
    while (!ERR_timeout && k < TIMEOUT + 40) begin
      tick();
      k++;
    end
    // Last word's edge, then TIMEOUT gap edges, then the registered pulse.
    chk("tmo_latency", 64'(k), 64'(TIMEOUT + 1));
    chk("tmo_rdy", 64'(RDY_start), 64'd1);
    chk("tmo_sum_kept", 64'(result_sum), 64'(last_sum));
    chk("tmo_max_kept", 64'(result_max), 64'(last_max));
    tick();
    chk("tmo_pulse_low", 64'(ERR_timeout), 64'd0);
    chk("tmo_err_once", 64'(err_cnt - er0), 64'd1);
    chk("tmo_no_result", 64'(vr_cnt - vr0), 64'd0);

    // Reset in the middle of a block, then stray words while idle.
    for (int i = 0; i < BLOCK_LEN; i++) words[i] = 32'(2 * i);
    vr0 = vr_cnt;
    start_block("mid");
    send_words(30, 0, 0);
    rst = 1'b1;
    tick();
    chk("mid_rst_rdy", 64'(RDY_start), 64'd0);
    rst = 1'b0;
    tick();
    chk("mid_rst_sum", 64'(result_sum), 64'd0);
    chk("mid_rst_rdy_back", 64'(RDY_start), 64'd1);
    VALID_memVal = 1'b1;
    memVal_data  = 32'hDEAD_BEEF;
    repeat (5) tick();
    VALID_memVal = 1'b0;
    memVal_data  = '0;
    chk("stray_no_result", 64'(vr_cnt - vr0), 64'd0);
    chk("stray_rdy", 64'(RDY_start), 64'd1);
    chk("stray_sum", 64'(result_sum), 64'd0);
    start_block("after_rst");
    push_expected(BLOCK_LEN);
    send_words(BLOCK_LEN, 0, 0);
    wait_result("after_rst");
    chk("after_rst_sum_const", 64'(result_sum), 64'd4032);
    chk("after_rst_one_result", 64'(vr_cnt - vr0), 64'd1);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
